// File: rtl/triangle_tf_feeder_pkg.sv
// Shared types for the triangle_tf feeder: triangle/transform payloads, stream
// metadata, the per-instance command record and the feeder FSM state encoding.
package triangle_tf_feeder_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int CNT_W_DEF  = 12;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } vertex_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

  typedef struct packed {
    logic [8:0][15:0] rotmat;
    logic [2:0][15:0] position;
  } transform_t;

  typedef struct packed {
    triangle_t  triangle;
    transform_t transform;
  } triangle_tf_t;

  typedef struct packed {
    logic triangle_last;
    logic model_last;
  } triangle_tf_meta_t;

  typedef struct packed {
    transform_t            transform;
    logic [ADDR_W_DEF-1:0] base;
    logic [CNT_W_DEF-1:0]  count;
    logic                  model_last;
  } feeder_cmd_t;

  typedef struct packed {
    triangle_tf_t      data;
    triangle_tf_meta_t meta;
  } fifo_entry_t;

  localparam int FIFO_W = $bits(fifo_entry_t);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } feeder_state_e;

  // Slots committed after this cycle: outstanding read plus buffered beats,
  // minus the beat leaving this cycle. A new read may issue while this is < 2.
  function automatic logic [1:0] credit_used(input logic in_flight,
                                             input logic [1:0] occupancy,
                                             input logic popping);
    return 2'(occupancy + {1'b0, in_flight} - {1'b0, popping});
  endfunction

endpackage

// File: rtl/triangle_tf_feeder_if.sv
// Bus bundle for the feeder: command slave, triangle memory read port and the
// triangle_tf master stream. Stats outputs exist only with TRIANGLE_TF_FEEDER_STATS_EN.
interface triangle_tf_feeder_if #(
  parameter int ADDR_W = triangle_tf_feeder_pkg::ADDR_W_DEF,
  parameter int CNT_W  = triangle_tf_feeder_pkg::CNT_W_DEF
);
  import triangle_tf_feeder_pkg::*;

  // valid/ready: a transfer happens on a rising clk edge where both are high;
  // the source holds payload stable while valid && !ready and never drops valid.
  transform_t        cmd_s_transform;
  logic [ADDR_W-1:0] cmd_s_base;
  logic [CNT_W-1:0]  cmd_s_count;
  logic              cmd_s_model_last;
  logic              cmd_s_valid;
  logic              cmd_s_ready;

  logic              tri_rd_en;
  logic [ADDR_W-1:0] tri_rd_addr;
  triangle_t         tri_rd_data;

  triangle_tf_t      triangle_tf_m_data;
  triangle_tf_meta_t triangle_tf_m_metadata;
  logic              triangle_tf_m_valid;
  logic              triangle_tf_m_ready;

`ifdef TRIANGLE_TF_FEEDER_STATS_EN
  logic [31:0]       stat_tri_count;
  logic [15:0]       stat_frame_count;
`endif

  modport master (
    input  cmd_s_transform, cmd_s_base, cmd_s_count, cmd_s_model_last, cmd_s_valid,
    output cmd_s_ready,
    output tri_rd_en, tri_rd_addr,
    input  tri_rd_data,
    output triangle_tf_m_data, triangle_tf_m_metadata, triangle_tf_m_valid,
    input  triangle_tf_m_ready
`ifdef TRIANGLE_TF_FEEDER_STATS_EN
    , output stat_tri_count, stat_frame_count
`endif
  );

  modport slave (
    output cmd_s_transform, cmd_s_base, cmd_s_count, cmd_s_model_last, cmd_s_valid,
    input  cmd_s_ready,
    input  tri_rd_en, tri_rd_addr,
    output tri_rd_data,
    input  triangle_tf_m_data, triangle_tf_m_metadata, triangle_tf_m_valid,
    output triangle_tf_m_ready
`ifdef TRIANGLE_TF_FEEDER_STATS_EN
    , input stat_tri_count, stat_frame_count
`endif
  );

endinterface

// File: rtl/triangle_tf_feeder_tf_fifo2.sv
// Two-entry FIFO of parameterised width with full/empty flags. Push and pop may
// coincide; a push into a full FIFO is accepted only when a pop frees a slot.
module tf_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/triangle_tf_feeder.sv
// Turns per-instance commands into one triangle_tf beat per triangle, reading a
// 1-cycle-latency triangle memory under a 2-slot credit. Optional stats: TRIANGLE_TF_FEEDER_STATS_EN.
module triangle_tf_feeder
  import triangle_tf_feeder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  triangle_tf_feeder_if.master bus,
  output feeder_state_e        dbg_state_o
);

  feeder_state_e     state_q, state_d;
  transform_t        transform_q, transform_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              model_last_q, model_last_d;
  triangle_tf_meta_t tag_q, tag_d;
  logic              rd_pend_q;

  logic              cmd_ready;
  logic              rd_en;
  logic              is_last;
  logic              credit_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_occ;
  logic              push;
  logic              pop;
  logic              out_valid;
  fifo_entry_t       push_entry;
  fifo_entry_t       head_entry;

  assign is_last   = (idx_q == count_q - CNT_W'(1));
  assign out_valid = !fifo_empty && !rst;
  assign pop       = out_valid && bus.triangle_tf_m_ready;
  assign push      = rd_pend_q;
  assign fifo_occ  = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign credit_ok = credit_used(rd_pend_q, fifo_occ, pop) < 2'd2;

  always_comb begin
    state_d      = state_q;
    transform_d  = transform_q;
    base_d       = base_q;
    count_d      = count_q;
    model_last_d = model_last_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    cmd_ready    = 1'b0;
    rd_en        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_s_valid) begin
          transform_d  = bus.cmd_s_transform;
          base_d       = bus.cmd_s_base;
          count_d      = bus.cmd_s_count;
          model_last_d = bus.cmd_s_model_last;
          idx_d        = '0;
          // A zero-count instance is consumed here with nothing emitted.
          if (bus.cmd_s_count != '0) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          idx_d = idx_q + CNT_W'(1);
          tag_d = '{triangle_last: is_last, model_last: is_last && model_last_q};
          if (is_last) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      transform_q  <= '0;
      base_q       <= '0;
      count_q      <= '0;
      model_last_q <= 1'b0;
      idx_q        <= '0;
      tag_q        <= '0;
      rd_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      transform_q  <= transform_d;
      base_q       <= base_d;
      count_q      <= count_d;
      model_last_q <= model_last_d;
      idx_q        <= idx_d;
      tag_q        <= tag_d;
      rd_pend_q    <= rd_en;
    end
  end

  // transform_q only changes on a command handshake, which cannot precede the
  // return of the previous instance's last read, so this pairing is safe.
  assign push_entry = {bus.tri_rd_data, transform_q, tag_q};

  tf_fifo2 #(
    .W(FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.cmd_s_ready            = cmd_ready && !rst;
  assign bus.tri_rd_en              = rd_en && !rst;
  assign bus.tri_rd_addr            = rst ? '0 : (base_q + ADDR_W'(idx_q));
  assign bus.triangle_tf_m_valid    = out_valid;
  assign bus.triangle_tf_m_data     = out_valid ? head_entry.data : '0;
  assign bus.triangle_tf_m_metadata = out_valid ? head_entry.meta : '0;
  assign dbg_state_o                = state_q;

`ifdef TRIANGLE_TF_FEEDER_STATS_EN
  logic [31:0] stat_tri_q;
  logic [15:0] stat_frame_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_tri_q   <= '0;
      stat_frame_q <= '0;
    end else if (pop) begin
      stat_tri_q <= stat_tri_q + 32'd1;
      if (head_entry.meta.model_last) begin
        stat_frame_q <= stat_frame_q + 16'd1;
      end
    end
  end

  assign bus.stat_tri_count   = stat_tri_q;
  assign bus.stat_frame_count = stat_frame_q;
`endif

endmodule

// File: tb/tb_triangle_tf_feeder.sv
// Bench for triangle_tf_feeder: directed scenarios plus random commands, scored
// against an expected-beat list built from each command and a triangle memory image.
module tb_triangle_tf_feeder;
  import triangle_tf_feeder_pkg::*;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 12;
  localparam int MEM_N  = 1 << ADDR_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  feeder_state_e dbg_state;

  triangle_tf_feeder_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  triangle_tf_feeder #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  triangle_t         tri_mem [MEM_N];
  logic [159:0]      rnd160;
  logic [FIFO_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] rd_exp_q[$];
  int                rd_cyc_log[$];
  int                beat_cyc_log[$];
  logic [ADDR_W-1:0] rd_addr_log[$];
  logic [1:0]        meta_log[$];
  transform_t        tf_log[$];
  int                issued = 0;
  int                popped = 0;
  int                beats_since_rst = 0;
  int                frames_since_rst = 0;
  int                hs_cyc = 0;
  int                ready_mode = 0;
  int                ready_phase = 0;
  logic              stall_vld = 1'b0;
  logic [FIFO_W-1:0] stall_data;
  logic [FIFO_W-1:0] cur_beat;

  // Synchronous memory model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.tri_rd_en) bus.tri_rd_data <= tri_mem[bus.tri_rd_addr];
  end

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic transform_t rand_tf();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Downstream ready: 0 = always high, 1 = random 75%, 2 = pattern 1,0,0,1.
  initial begin
    bus.triangle_tf_m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_phase++;
      case (ready_mode)
        0:       bus.triangle_tf_m_ready = 1'b1;
        1:       bus.triangle_tf_m_ready = ($urandom_range(0, 3) != 0);
        default: bus.triangle_tf_m_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
      endcase
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.triangle_tf_m_valid) begin
        cur_beat = {bus.triangle_tf_m_data, bus.triangle_tf_m_metadata};
        if (stall_vld) check("stall_stable", cur_beat, stall_data);
        if (bus.triangle_tf_m_ready) begin
          popped++;
          beats_since_rst++;
          if (bus.triangle_tf_m_metadata.model_last) frames_since_rst++;
          beat_cyc_log.push_back(cyc);
          meta_log.push_back(bus.triangle_tf_m_metadata);
          tf_log.push_back(bus.triangle_tf_m_data.transform);
          if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
          else check("beat", cur_beat, exp_q.pop_front());
          stall_vld = 1'b0;
        end else begin
          stall_vld  = 1'b1;
          stall_data = cur_beat;
        end
      end else if (stall_vld) begin
        check("valid_held", 0, 1);
        stall_vld = 1'b0;
      end
      if (bus.tri_rd_en) begin
        issued++;
        rd_cyc_log.push_back(cyc);
        rd_addr_log.push_back(bus.tri_rd_addr);
        if (rd_exp_q.size() == 0) check("rd_unexpected", 1, 0);
        else check("rd_addr", bus.tri_rd_addr, rd_exp_q.pop_front());
        check("credit_le2", (issued - popped) <= 2, 1);
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after the handshake.
  task automatic send_cmd(input transform_t tf, input logic [ADDR_W-1:0] base,
                          input logic [CNT_W-1:0] count, input logic ml);
    int budget = 0;
    bus.cmd_s_transform  = tf;
    bus.cmd_s_base       = base;
    bus.cmd_s_count      = count;
    bus.cmd_s_model_last = ml;
    bus.cmd_s_valid      = 1'b1;
    while (!bus.cmd_s_ready && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.cmd_s_ready) begin
      check("cmd_accept_timeout", 0, 1);
      bus.cmd_s_valid = 1'b0;
      return;
    end
    hs_cyc = cyc;
    for (int i = 0; i < int'(count); i++) begin
      int   a;
      logic tl;
      a  = (int'(base) + i) % MEM_N;
      tl = (i == int'(count) - 1);
      rd_exp_q.push_back(ADDR_W'(a));
      exp_q.push_back({tri_mem[a], tf, tl, tl && ml});
    end
    @(negedge clk);
    bus.cmd_s_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while ((exp_q.size() != 0 || rd_exp_q.size() != 0) && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    check("drain_done", exp_q.size() + rd_exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_logs();
    rd_cyc_log.delete();
    beat_cyc_log.delete();
    rd_addr_log.delete();
    meta_log.delete();
    tf_log.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    transform_t tf_a, tf_b;
    int h;
    int budget;
    logic found;
    for (int i = 0; i < MEM_N; i++) begin
      rnd160 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      tri_mem[i] = rnd160[143:0];
    end
    bus.cmd_s_valid      = 1'b0;
    bus.cmd_s_transform  = '0;
    bus.cmd_s_base       = '0;
    bus.cmd_s_count      = '0;
    bus.cmd_s_model_last = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_s_ready, 0);
    check("rst_rd_en", bus.tri_rd_en, 0);
    check("rst_rd_addr", bus.tri_rd_addr, 0);
    check("rst_valid", bus.triangle_tf_m_valid, 0);
    check("rst_data", bus.triangle_tf_m_data, 0);
    check("rst_meta", bus.triangle_tf_m_metadata, 0);
    check("rst_state", dbg_state, S_IDLE);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.cmd_s_ready, 1);

    // Single instance: latency, consecutive reads, metadata
    ready_mode = 0;
    clear_logs();
    send_cmd(rand_tf(), 12'd5, 12'd3, 1'b1);
    h = hs_cyc;
    drain();
    check("t1_nreads", rd_cyc_log.size(), 3);
    check("t1_nbeats", beat_cyc_log.size(), 3);
    if (rd_cyc_log.size() == 3 && beat_cyc_log.size() == 3) begin
      check("t1_rd0_cycle", rd_cyc_log[0], h + 1);
      check("t1_rd2_cycle", rd_cyc_log[2], h + 3);
      check("t1_addr0", rd_addr_log[0], 5);
      check("t1_first_valid", beat_cyc_log[0], h + 3);
      check("t1_meta0", meta_log[0], 2'b00);
      check("t1_meta1", meta_log[1], 2'b00);
      check("t1_meta2", meta_log[2], 2'b11);
    end

    // Address wrap
    clear_logs();
    send_cmd(rand_tf(), 12'hFFE, 12'd4, 1'b0);
    drain();
    check("wrap_nreads", rd_addr_log.size(), 4);
    if (rd_addr_log.size() == 4) begin
      check("wrap_addr1", rd_addr_log[1], 12'hFFF);
      check("wrap_addr2", rd_addr_log[2], 12'h000);
      check("wrap_addr3", rd_addr_log[3], 12'h001);
    end

    // Backpressure 1,0,0,1
    ready_mode = 2;
    clear_logs();
    send_cmd(rand_tf(), 12'd100, 12'd8, 1'b1);
    drain();
    check("bp_nbeats", meta_log.size(), 8);
    if (meta_log.size() == 8) check("bp_last_meta", meta_log[7], 2'b11);
    ready_mode = 0;
    @(negedge clk);

    // Back-to-back commands
    clear_logs();
    tf_a = rand_tf();
    tf_b = rand_tf();
    send_cmd(tf_a, 12'd200, 12'd2, 1'b0);
    send_cmd(tf_b, 12'd300, 12'd1, 1'b1);
    drain();
    check("b2b_nbeats", meta_log.size(), 3);
    if (meta_log.size() == 3 && rd_cyc_log.size() == 3) begin
      check("b2b_meta_a1", meta_log[1], 2'b10);
      check("b2b_meta_b", meta_log[2], 2'b11);
      check("b2b_tf_a0", tf_log[0], tf_a);
      check("b2b_tf_a1", tf_log[1], tf_a);
      check("b2b_tf_b", tf_log[2], tf_b);
      check("b2b_gap", rd_cyc_log[2] - rd_cyc_log[1], 2);
    end

    // Zero count
    clear_logs();
    send_cmd(rand_tf(), 12'd50, 12'd0, 1'b1);
    check("zero_ready_again", bus.cmd_s_ready, 1);
    check("zero_state_idle", dbg_state, S_IDLE);
    repeat (6) @(negedge clk);
    check("zero_no_reads", rd_cyc_log.size(), 0);
    check("zero_no_beats", beat_cyc_log.size(), 0);

    // Reset mid-run at index 4
    clear_logs();
    send_cmd(rand_tf(), 12'd400, 12'd10, 1'b1);
    budget = 0;
    found  = 1'b0;
    while (budget < 50 && !found) begin
      if (bus.tri_rd_en && bus.tri_rd_addr == 12'd404) found = 1'b1;
      else begin
        @(negedge clk);
        budget++;
      end
    end
    check("rstrun_index4_seen", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstrun_valid", bus.triangle_tf_m_valid, 0);
    check("rstrun_rd_en", bus.tri_rd_en, 0);
    check("rstrun_ready_low", bus.cmd_s_ready, 0);
    exp_q.delete();
    rd_exp_q.delete();
    issued = 0;
    popped = 0;
    beats_since_rst = 0;
    frames_since_rst = 0;
    stall_vld = 1'b0;
    clear_logs();
    rst = 1'b0;
    @(negedge clk);
    check("rstrun_ready_high", bus.cmd_s_ready, 1);
    check("rstrun_valid_after", bus.triangle_tf_m_valid, 0);
    repeat (8) @(negedge clk);
    check("rstrun_no_stale", beat_cyc_log.size() + rd_cyc_log.size(), 0);

    // Random commands under varying readiness
    for (int n = 0; n < 40; n++) begin
      ready_mode = $urandom_range(0, 2);
      send_cmd(rand_tf(), ADDR_W'($urandom_range(0, MEM_N - 1)),
               ($urandom_range(0, 5) == 0) ? CNT_W'(0) : CNT_W'($urandom_range(1, 24)),
               1'($urandom_range(0, 1)));
    end
    drain();

    // Maximum count
    ready_mode = 0;
    clear_logs();
    send_cmd(rand_tf(), 12'hF00, 12'hFFF, 1'b1);
    drain();
    check("max_nbeats", meta_log.size(), 4095);
    if (meta_log.size() == 4095) begin
      check("max_meta_first", meta_log[0], 2'b00);
      check("max_meta_last", meta_log[4094], 2'b11);
    end

`ifdef TRIANGLE_TF_FEEDER_STATS_EN
    check("stat_tri", bus.stat_tri_count, beats_since_rst);
    check("stat_frame", bus.stat_frame_count, frames_since_rst);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
